// File: rtl/cnt_gate_ctrl.sv
// cnt_gate_ctrl: measurement-window controller for the filtered event counter.
// Each window clears the counter, opens the count gate for GATE_TICKS cycles,
// lets the counter's input filter drain, then snapshots the count and offers it
// on a valid/ready port together with a wrap flag and a sticky overrun flag.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for i_run; gate closed, counter not cleared
// ST_CLR     | o_cnt_rst high for CLR_CYCLES; wrap flag and sample reg cleared
// ST_GATE    | o_cnt_en high for GATE_TICKS; wrap detection active
// ST_SETTLE  | gate closed for SETTLE_CYCLES so filtered events land; wrap detection active
// ST_SAMPLE  | capture i_cnt into the result holding reg
// ST_LATCH   | hand the result to the output port or flag an overrun
module cnt_gate_ctrl #(
  parameter int CNT_WIDTH     = 8,
  parameter int GATE_TICKS    = 1000,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_run,
  input  logic [CNT_WIDTH-1:0] i_cnt,
  output logic                 o_cnt_en,
  output logic                 o_cnt_rst,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_data,
  output logic                 o_ovf,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overrun
);

  localparam int GATE_W  = $clog2(GATE_TICKS + 1);
  localparam int AUX_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int AUX_W   = $clog2(AUX_MAX + 1);

  // Down-counters are loaded with N-1 and the state advances on terminal count 0,
  // so each timed state lasts exactly N cycles.
  localparam logic [GATE_W-1:0] GATE_LOAD   = GATE_W'(GATE_TICKS - 1);
  localparam logic [AUX_W-1:0]  CLR_LOAD    = AUX_W'(CLR_CYCLES - 1);
  localparam logic [AUX_W-1:0]  SETTLE_LOAD = AUX_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_GATE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_LATCH
  } state_t;

  state_t               state;
  logic [GATE_W-1:0]    gate_tmr;
  logic [AUX_W-1:0]     aux_tmr;
  logic [CNT_WIDTH-1:0] s_cnt;
  logic [CNT_WIDTH-1:0] res;
  logic                 wrap;

  // Window sequencer with registered outputs, wrap detection and output handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      gate_tmr  <= '0;
      aux_tmr   <= '0;
      s_cnt     <= '0;
      res       <= '0;
      wrap      <= 1'b0;
      o_cnt_en  <= 1'b0;
      o_cnt_rst <= 1'b0;
      o_busy    <= 1'b0;
      o_data    <= '0;
      o_ovf     <= 1'b0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      // Consumer takes the result; LATCH below may reload in the same cycle.
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (i_run) begin
            state     <= ST_CLR;
            o_cnt_rst <= 1'b1;
            o_busy    <= 1'b1;
            aux_tmr   <= CLR_LOAD;
          end
        end

        ST_CLR: begin
          wrap  <= 1'b0;
          res   <= '0;
          // The counter reads zero once cleared, so the wrap reference starts at zero.
          s_cnt <= '0;
          if (!i_run) begin
            state     <= ST_IDLE;
            o_cnt_rst <= 1'b0;
            o_busy    <= 1'b0;
          end else if (aux_tmr == '0) begin
            state     <= ST_GATE;
            o_cnt_rst <= 1'b0;
            o_cnt_en  <= 1'b1;
            gate_tmr  <= GATE_LOAD;
          end else begin
            aux_tmr <= aux_tmr - 1'b1;
          end
        end

        ST_GATE: begin
          s_cnt <= i_cnt;
          if (i_cnt < s_cnt) begin
            wrap <= 1'b1;
          end
          if (!i_run) begin
            state    <= ST_IDLE;
            o_cnt_en <= 1'b0;
            o_busy   <= 1'b0;
          end else if (gate_tmr == '0) begin
            state    <= ST_SETTLE;
            o_cnt_en <= 1'b0;
            aux_tmr  <= SETTLE_LOAD;
          end else begin
            gate_tmr <= gate_tmr - 1'b1;
          end
        end

        ST_SETTLE: begin
          // Events still in the counter's input filter can wrap it here too.
          s_cnt <= i_cnt;
          if (i_cnt < s_cnt) begin
            wrap <= 1'b1;
          end
          if (aux_tmr == '0) begin
            state <= ST_SAMPLE;
          end else begin
            aux_tmr <= aux_tmr - 1'b1;
          end
        end

        ST_SAMPLE: begin
          res   <= i_cnt;
          state <= ST_LATCH;
        end

        ST_LATCH: begin
          if (!o_valid || i_ready) begin
            o_data  <= res;
            o_ovf   <= wrap;
            o_valid <= 1'b1;
          end else begin
            o_overrun <= 1'b1;
          end
          if (i_run) begin
            state     <= ST_CLR;
            o_cnt_rst <= 1'b1;
            aux_tmr   <= CLR_LOAD;
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          o_cnt_en  <= 1'b0;
          o_cnt_rst <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_gate_ctrl.sv
// Bench for cnt_gate_ctrl: an 8-bit instance fed by a divide-by-16 counter model
// and a 4-bit instance fed by a counter that counts every gated cycle.
module tb_cnt_gate_ctrl;

  localparam int GATE   = 64;
  localparam int CLR    = 2;
  localparam int SETTLE = 17;
  localparam int PRESC  = 16;
  // Edges after the run-sampling edge at which o_valid first reads high.
  localparam int VALID_AT = CLR + GATE + SETTLE + 2;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       run8 = 1'b0, ready8 = 1'b0;
  logic       run4 = 1'b0, ready4 = 1'b0;
  logic [7:0] cnt8;
  logic [3:0] pre8;
  logic [3:0] cnt4;

  logic       en8, crst8, busy8, ovf8, valid8, ovr8;
  logic [7:0] data8;
  logic       en4, crst4, busy4, ovf4, valid4, ovr4;
  logic [3:0] data4;

  int n_pass  = 0;
  int n_total = 0;

  res_t sb8[$];
  res_t sb4[$];

  cnt_gate_ctrl #(.CNT_WIDTH(8), .GATE_TICKS(GATE), .CLR_CYCLES(CLR), .SETTLE_CYCLES(SETTLE)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_run(run8), .i_cnt(cnt8),
    .o_cnt_en(en8), .o_cnt_rst(crst8), .o_busy(busy8), .o_data(data8),
    .o_ovf(ovf8), .o_valid(valid8), .i_ready(ready8), .o_overrun(ovr8)
  );

  cnt_gate_ctrl #(.CNT_WIDTH(4), .GATE_TICKS(GATE), .CLR_CYCLES(CLR), .SETTLE_CYCLES(SETTLE)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_run(run4), .i_cnt(cnt4),
    .o_cnt_en(en4), .o_cnt_rst(crst4), .o_busy(busy4), .o_data(data4),
    .o_ovf(ovf4), .o_valid(valid4), .i_ready(ready4), .o_overrun(ovr4)
  );

  // Counter stage model: +1 every PRESC enabled clocks.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt8 <= 8'd0;
      pre8 <= 4'd0;
    end else if (crst8) begin
      cnt8 <= 8'd0;
      pre8 <= 4'd0;
    end else if (en8) begin
      if (pre8 == 4'(PRESC - 1)) begin
        cnt8 <= cnt8 + 8'd1;
        pre8 <= 4'd0;
      end else begin
        pre8 <= pre8 + 4'd1;
      end
    end
  end

  // Narrow counter model: +1 every enabled clock, wraps at 16.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt4 <= 4'd0;
    else if (crst4) cnt4 <= 4'd0;
    else if (en4) cnt4 <= cnt4 + 4'd1;
  end

  task automatic test_reset();
    logic busy_seen;
    busy_seen = 1'b0;
    rst = 1'b1;
    run8 = 1'b0;
    run4 = 1'b0;
    #3;
    n_total++;
    if ({en8, crst8, busy8, data8, ovf8, valid8, ovr8} !== 14'd0) $display("FAIL reset_out8: got %h expected 0", {en8, crst8, busy8, data8, ovf8, valid8, ovr8});
    else n_pass++;
    n_total++;
    if ({en4, crst4, busy4, data4, ovf4, valid4, ovr4} !== 10'd0) $display("FAIL reset_out4: got %h expected 0", {en4, crst4, busy4, data4, ovf4, valid4, ovr4});
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (busy8 || busy4) busy_seen = 1'b1;
    end
    n_total++;
    if (busy_seen !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy_seen);
    else n_pass++;
  endtask

  task automatic test_single_window();
    int rst_first = -1, rst_cnt = 0, en_first = -1, en_cnt = 0, v_first = -1;
    logic v_after = 1'b1;
    logic busy_end = 1'b1;
    res_t ex, e;
    ex.data = 8'((GATE / PRESC) % 256);
    ex.ovf  = ((GATE / PRESC) >= 256);
    @(posedge clk);
    #1;
    ready8 = 1'b1;
    run8 = 1'b1;
    sb8.push_back(ex);
    @(posedge clk);
    for (int n = 0; n < 96; n++) begin
      #1;
      if (crst8) begin
        if (rst_first < 0) rst_first = n;
        rst_cnt++;
      end
      if (en8) begin
        if (en_first < 0) en_first = n;
        en_cnt++;
      end
      if (v_first >= 0 && n == v_first + 1) v_after = valid8;
      if (valid8 && v_first < 0) begin
        v_first = n;
        n_total++;
        if (sb8.size() == 0) $display("FAIL single_sb: scoreboard empty on valid");
        else begin
          e = sb8.pop_front();
          if ({data8, ovf8} !== e) $display("FAIL single_data: got data=%0d ovf=%b expected data=%0d ovf=%b", data8, ovf8, e.data, e.ovf);
          else n_pass++;
        end
      end
      if (n == 95) busy_end = busy8;
      if (n == 70) run8 = 1'b0;
      @(posedge clk);
    end
    n_total++;
    if (rst_first !== 0 || rst_cnt !== CLR) $display("FAIL single_clr: got first=%0d len=%0d expected first=0 len=%0d", rst_first, rst_cnt, CLR);
    else n_pass++;
    n_total++;
    if (en_first !== CLR || en_cnt !== GATE) $display("FAIL single_gate: got first=%0d len=%0d expected first=%0d len=%0d", en_first, en_cnt, CLR, GATE);
    else n_pass++;
    n_total++;
    if (v_first !== VALID_AT) $display("FAIL single_valid_time: got %0d expected %0d", v_first, VALID_AT);
    else n_pass++;
    n_total++;
    if (v_after !== 1'b0) $display("FAIL single_valid_drop: got %b expected 0", v_after);
    else n_pass++;
    n_total++;
    if (busy_end !== 1'b0) $display("FAIL single_idle_after: got busy=%b expected 0", busy_end);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int v_first = -1;
    res_t ex, e;
    ex.data = 8'(GATE % 16);
    ex.ovf  = (GATE >= 16);
    @(posedge clk);
    #1;
    ready4 = 1'b1;
    run4 = 1'b1;
    sb4.push_back(ex);
    @(posedge clk);
    for (int n = 0; n < 100; n++) begin
      #1;
      if (valid4 && v_first < 0) begin
        v_first = n;
        n_total++;
        if (sb4.size() == 0) $display("FAIL wrap_sb: scoreboard empty on valid");
        else begin
          e = sb4.pop_front();
          if ({4'd0, data4, ovf4} !== e) $display("FAIL wrap_data: got data=%0d ovf=%b expected data=%0d ovf=%b", data4, ovf4, e.data, e.ovf);
          else n_pass++;
        end
      end
      if (n == 70) run4 = 1'b0;
      @(posedge clk);
    end
    n_total++;
    if (v_first !== VALID_AT) $display("FAIL wrap_valid_time: got %0d expected %0d", v_first, VALID_AT);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int v_first = -1;
    logic [7:0] first_data = 8'd0;
    logic stable = 1'b1;
    logic held = 1'b0;
    logic ovr_pre = 1'b1, ovr_post = 1'b0, v_drop = 1'b1, ovr_sticky = 1'b0;
    res_t ex, e;
    ex.data = 8'((GATE / PRESC) % 256);
    ex.ovf  = ((GATE / PRESC) >= 256);
    @(posedge clk);
    #1;
    ready8 = 1'b0;
    run8 = 1'b1;
    sb8.push_back(ex);
    @(posedge clk);
    for (int n = 0; n < 185; n++) begin
      #1;
      if (valid8 && v_first < 0) begin
        v_first = n;
        first_data = data8;
        n_total++;
        if (sb8.size() == 0) $display("FAIL bp_sb: scoreboard empty on valid");
        else begin
          e = sb8.pop_front();
          if ({data8, ovf8} !== e) $display("FAIL bp_data: got data=%0d ovf=%b expected data=%0d ovf=%b", data8, ovf8, e.data, e.ovf);
          else n_pass++;
        end
      end
      if (v_first >= 0 && n <= 180 && (data8 !== first_data || valid8 !== 1'b1)) stable = 1'b0;
      if (n == VALID_AT + 1) held = valid8;
      if (n == 2 * VALID_AT - 1) ovr_pre = ovr8;
      if (n == 2 * VALID_AT) ovr_post = ovr8;
      if (n == 172) run8 = 1'b0;
      if (n == 180) ready8 = 1'b1;
      if (n == 181) begin
        v_drop = valid8;
        ovr_sticky = ovr8;
      end
      @(posedge clk);
    end
    n_total++;
    if (held !== 1'b1) $display("FAIL bp_hold: got valid=%b expected 1", held);
    else n_pass++;
    n_total++;
    if (stable !== 1'b1 || v_first !== VALID_AT) $display("FAIL bp_stable: got stable=%b first=%0d expected stable=1 first=%0d", stable, v_first, VALID_AT);
    else n_pass++;
    n_total++;
    if (ovr_pre !== 1'b0 || ovr_post !== 1'b1) $display("FAIL bp_overrun: got pre=%b post=%b expected pre=0 post=1", ovr_pre, ovr_post);
    else n_pass++;
    n_total++;
    if (v_drop !== 1'b0 || ovr_sticky !== 1'b1) $display("FAIL bp_release: got valid=%b overrun=%b expected valid=0 overrun=1", v_drop, ovr_sticky);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic en_before = 1'b0, en_after = 1'b1, busy_after = 1'b1, v_seen = 1'b0;
    @(posedge clk);
    #1;
    ready8 = 1'b1;
    run8 = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 110; n++) begin
      #1;
      if (valid8) v_seen = 1'b1;
      if (n == CLR + 9) begin
        en_before = en8;
        run8 = 1'b0;
      end
      if (n == CLR + 10) begin
        en_after = en8;
        busy_after = busy8;
      end
      @(posedge clk);
    end
    n_total++;
    if (en_before !== 1'b1 || en_after !== 1'b0 || busy_after !== 1'b0) $display("FAIL abort_gate: got en_before=%b en_after=%b busy=%b expected 1 0 0", en_before, en_after, busy_after);
    else n_pass++;
    n_total++;
    if (v_seen !== 1'b0) $display("FAIL abort_no_valid: got %b expected 0", v_seen);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int v_first = -1;
    res_t ex, e;
    ex.data = 8'((GATE / PRESC) % 256);
    ex.ovf  = ((GATE / PRESC) >= 256);
    @(posedge clk);
    #1;
    ready8 = 1'b1;
    run8 = 1'b1;
    @(posedge clk);
    repeat (70) @(posedge clk);
    #3;
    n_total++;
    if (busy8 !== 1'b1 || en8 !== 1'b0) $display("FAIL arst_pre: got busy=%b en=%b expected busy=1 en=0", busy8, en8);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({en8, crst8, busy8, data8, ovf8, valid8, ovr8} !== 14'd0) $display("FAIL arst_out: got %h expected 0", {en8, crst8, busy8, data8, ovf8, valid8, ovr8});
    else n_pass++;
    run8 = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run8 = 1'b1;
    sb8.push_back(ex);
    @(posedge clk);
    for (int n = 0; n < 96; n++) begin
      #1;
      if (valid8 && v_first < 0) begin
        v_first = n;
        n_total++;
        if (sb8.size() == 0) $display("FAIL arst_sb: scoreboard empty on valid");
        else begin
          e = sb8.pop_front();
          if ({data8, ovf8} !== e) $display("FAIL arst_data: got data=%0d ovf=%b expected data=%0d ovf=%b", data8, ovf8, e.data, e.ovf);
          else n_pass++;
        end
      end
      if (n == 70) run8 = 1'b0;
      @(posedge clk);
    end
    n_total++;
    if (v_first !== VALID_AT) $display("FAIL arst_restart_time: got %0d expected %0d", v_first, VALID_AT);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_wrap();
    test_backpressure();
    test_abort();
    test_async_reset();
    n_total++;
    if (sb8.size() != 0 || sb4.size() != 0) $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", sb8.size(), sb4.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
